stc1_egress_packer: RTL and testbench

STC1_EGRESS_PACKER -- requirements
Module: stc1_egress_packer

---
 rtl/stc1_egress_packer.sv | 147 ++++++++++++++
 tb/tb_stc1_egress_packer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stc1_egress_packer.sv
// stc1_egress_packer: FIFO-buffered complex sample words serialised into byte frames {hdr, data..[, chk]}
// Optional checksum byte is enabled by defining STC1_EGRESS_CHKSUM_EN.
module stc1_egress_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 2,
    parameter int FIFO_AW    = 4
) (
    input  logic                             Clk,
    input  logic                             ARstn,
    input  logic [NUM_CH*2*DATA_WIDTH-1:0]   IngressData,
    input  logic                             IngressValid,
    output logic                             IngressReady,
    input  logic [NUM_CH-1:0]                ChMask,
    output logic [7:0]                       ED,
    output logic                             EValid,
    input  logic                             ERdy,
    output logic                             Busy,
    output logic                             FrameDone
);
    localparam int CW    = 2 * DATA_WIDTH;
    localparam int WW    = NUM_CH * CW;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BPC   = DATA_WIDTH / 4;
    localparam int BW    = $clog2(BPC);
    localparam int CHW   = NUM_CH > 1 ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
`ifdef STC1_EGRESS_CHKSUM_EN
    localparam logic [1:0] S_CHK  = 2'd3;
`endif

    logic [WW-1:0]      mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               push, pop, empty;
    logic [1:0]         state;
    logic [WW-1:0]      frame_word;
    logic [NUM_CH-1:0]  rem;
    logic [BW-1:0]      bidx;
    logic [3:0]         seq;
    logic [CHW-1:0]     cur_ch;
    logic [7:0]         data_byte;
    logic               fire, last_byte, last_ch, end_frame;
`ifdef STC1_EGRESS_CHKSUM_EN
    logic [7:0]         csum;
`endif

    assign IngressReady = count != (FIFO_AW+1)'(DEPTH);
    assign empty        = count == '0;
    assign push         = IngressValid && IngressReady;
    assign EValid       = state != S_IDLE;
    assign fire         = EValid && ERdy;
    assign FrameDone    = fire && end_frame;
    assign pop          = !empty && (state == S_IDLE || FrameDone);
    assign Busy         = EValid || !empty;
    assign last_byte    = bidx == BW'(BPC - 1);
    assign last_ch      = (rem & (rem - NUM_CH'(1))) == '0;
`ifdef STC1_EGRESS_CHKSUM_EN
    assign end_frame    = state == S_CHK;
`else
    assign end_frame    = (state == S_HDR && rem == '0) || (state == S_DATA && last_byte && last_ch);
`endif

    // Current channel is the lowest still-pending bit of the latched mask
    always_comb begin
        cur_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (rem[i]) cur_ch = CHW'(i);
    end

    // Byte select: channel slice walked from its MSB (real MSB first, imag LSB last)
    always_comb begin
        data_byte = 8'(frame_word >> (int'(cur_ch) * CW + CW - 8 - 8 * int'(bidx)));
    end

    // Egress byte mux; zero outside a frame so reset drives ED low
    always_comb begin
        ED = 8'h00;
        if (state == S_HDR) ED = {4'hA, seq};
        else if (state == S_DATA) ED = data_byte;
`ifdef STC1_EGRESS_CHKSUM_EN
        else if (state == S_CHK) ED = csum;
`endif
    end

    // FIFO storage, unreset since occupancy governs validity
    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr] <= IngressData;
    end

    // FIFO pointers and registered occupancy
    always_ff @(posedge Clk or negedge ARstn) begin
        if (!ARstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
            count <= count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        end
    end

    // Frame FSM: pop/latch on frame start, walk header, channels and optional checksum
    always_ff @(posedge Clk or negedge ARstn) begin
        if (!ARstn) begin
            state      <= S_IDLE;
            seq        <= '0;
            rem        <= '0;
            bidx       <= '0;
            frame_word <= '0;
        end else begin
            if (FrameDone) seq <= seq + 4'd1;
            if (pop) begin
                state      <= S_HDR;
                frame_word <= mem[rd_ptr];
                rem        <= ChMask;
                bidx       <= '0;
            end else if (FrameDone) begin
                state <= S_IDLE;
            end else if (fire && state == S_HDR) begin
`ifdef STC1_EGRESS_CHKSUM_EN
                state <= rem == '0 ? S_CHK : S_DATA;
`else
                state <= S_DATA;
`endif
            end else if (fire && state == S_DATA) begin
                bidx <= last_byte ? '0 : bidx + BW'(1);
                if (last_byte) rem <= rem & (rem - NUM_CH'(1));
`ifdef STC1_EGRESS_CHKSUM_EN
                if (last_byte && last_ch) state <= S_CHK;
`endif
            end
        end
    end

`ifdef STC1_EGRESS_CHKSUM_EN
    // Mod-256 sum of DATA bytes, cleared at each frame start
    always_ff @(posedge Clk or negedge ARstn) begin
        if (!ARstn) csum <= '0;
        else if (pop) csum <= '0;
        else if (fire && state == S_DATA) csum <= csum + data_byte;
    end
`endif
endmodule

// File: tb/tb_stc1_egress_packer.sv
// tb_stc1_egress_packer: directed + randomized bench with a byte-queue reference model
module tb_stc1_egress_packer;
    localparam int DW = 16;
    localparam int NC = 2;
    localparam int AW = 4;
    localparam int WW = NC * 2 * DW;
`ifdef STC1_EGRESS_CHKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam logic [7:0] F0 [9] = '{8'hA0, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    localparam logic [7:0] F1 [5] = '{8'hA1, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    localparam logic [WW-1:0] W0 = 64'h9ABCDEF0_12345678;

    logic          Clk = 1'b0;
    logic          ARstn = 1'b0;
    logic [WW-1:0] IngressData = '0;
    logic          IngressValid = 1'b0;
    logic          IngressReady;
    logic [NC-1:0] ChMask = 2'b11;
    logic [7:0]    ED;
    logic          EValid;
    logic          ERdy = 1'b1;
    logic          Busy;
    logic          FrameDone;

    int tests = 0, fails = 0;
    logic [8:0] exp_q [$];
    logic [8:0] e;
    logic [3:0] model_seq = 4'd0;
    int cyc = 0, xfers = 0, first_cyc = 0, last_cyc = 0, frames = 0;
    int erdy_mode = 0, bp_ph = 0;
    logic prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0] prev_d = '0;

    always #5 Clk = ~Clk;

    stc1_egress_packer #(.DATA_WIDTH(DW), .NUM_CH(NC), .FIFO_AW(AW)) dut (
        .Clk(Clk), .ARstn(ARstn), .IngressData(IngressData), .IngressValid(IngressValid),
        .IngressReady(IngressReady), .ChMask(ChMask), .ED(ED), .EValid(EValid),
        .ERdy(ERdy), .Busy(Busy), .FrameDone(FrameDone)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: header, then per enabled channel real then imag, each MSB byte first, optional sum
    task automatic gen_frame(input logic [WW-1:0] w, input logic [NC-1:0] m);
        logic [7:0] fb [$];
        logic [7:0] sum = 8'h00;
        logic [DW-1:0] part;
        fb.push_back({4'hA, model_seq});
        for (int k = 0; k < NC; k++) begin
            if (m[k]) begin
                for (int p = 1; p >= 0; p--) begin
                    part = DW'(w >> (k * 2 * DW + p * DW));
                    for (int j = DW / 8 - 1; j >= 0; j--) begin
                        fb.push_back(8'(part >> (8 * j)));
                        sum = sum + 8'(part >> (8 * j));
                    end
                end
            end
        end
        if (CHK) fb.push_back(sum);
        for (int i = 0; i < fb.size(); i++) exp_q.push_back({i == fb.size() - 1, fb[i]});
        model_seq = model_seq + 4'd1;
    endtask

    task automatic push(input logic [WW-1:0] w, input logic [NC-1:0] m);
        int n = 0;
        @(negedge Clk);
        IngressData = w;
        IngressValid = 1'b1;
        #2;
        while (IngressReady !== 1'b1 && n < 3000) begin
            @(negedge Clk);
            #2;
            n++;
        end
        check("push_timeout", 32'(n < 3000), 1);
        gen_frame(w, m);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge Clk);
            IngressValid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        @(negedge Clk);
        IngressValid = 1'b0;
        #2;
        while ((exp_q.size() != 0 || Busy) && n < 5000) begin
            @(negedge Clk);
            #2;
            n++;
        end
        check("drain_timeout", 32'(n < 5000), 1);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        ARstn = 1'b0;
        IngressValid = 1'b0;
        #2;
        check("rst_ed", ED, 0);
        check("rst_evalid", EValid, 0);
        check("rst_framedone", FrameDone, 0);
        check("rst_busy", Busy, 0);
        exp_q.delete();
        model_seq = 4'd0;
        repeat (2) @(negedge Clk);
        ARstn = 1'b1;
        #2;
        check("rst_ready", IngressReady, 1);
    endtask

    always @(negedge Clk) begin
        case (erdy_mode)
            0: ERdy = 1'b1;
            1: ERdy = 1'b0;
            2: begin
                ERdy = (bp_ph % 4 == 0) || (bp_ph % 4 == 3);
                bp_ph++;
            end
            default: ERdy = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge Clk) begin
        #1;
        cyc++;
        if (ARstn !== 1'b1) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                check("hold_evalid", EValid, 1);
                check("hold_ed", ED, prev_d);
            end
            if (EValid && ERdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte_qsize", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", ED, e[7:0]);
                    check("frame_done", FrameDone, e[8]);
                end
                if (xfers == 0) first_cyc = cyc;
                last_cyc = cyc;
                xfers++;
                if (FrameDone) frames++;
            end else begin
                check("frame_done_idle", FrameDone, 0);
            end
            prev_v = EValid;
            prev_r = ERdy;
            prev_d = ED;
        end
    end

    initial begin
        int n;
        #2;
        check("init_ed", ED, 0);
        check("init_evalid", EValid, 0);
        check("init_framedone", FrameDone, 0);
        check("init_busy", Busy, 0);
        @(negedge Clk);
        ARstn = 1'b1;
        #2;
        check("init_ready", IngressReady, 1);

        // full mask frame then partial-mask frame back to back, with latency and mid-frame mask change
        ChMask = 2'b11;
        xfers = 0;
        @(negedge Clk);
        IngressData = W0;
        IngressValid = 1'b1;
        #2;
        check("acc0", IngressReady, 1);
        for (int i = 0; i < 9; i++) exp_q.push_back({!CHK && i == 8, F0[i]});
        if (CHK) exp_q.push_back({1'b1, 8'h38});
        @(negedge Clk);
        #2;
        check("lat_t1_evalid", EValid, 0);
        check("acc1", IngressReady, 1);
        for (int i = 0; i < 5; i++) exp_q.push_back({!CHK && i == 4, F1[i]});
        if (CHK) exp_q.push_back({1'b1, 8'h24});
        @(negedge Clk);
        IngressValid = 1'b0;
        #2;
        check("lat_t2_evalid", EValid, 1);
        check("lat_t2_hdr", ED, 8'hA0);
        idle(2);
        ChMask = 2'b10;
        drain();
        check("b2b_count", xfers, CHK ? 16 : 14);
        check("b2b_span", last_cyc - first_cyc, xfers - 1);

        // backpressure 1,0,0,1
        do_reset();
        ChMask = 2'b11;
        bp_ph = 0;
        erdy_mode = 2;
        push(W0, 2'b11);
        drain();
        erdy_mode = 0;

        // FIFO full: one word goes straight to the frame register, DEPTH more fill the FIFO
        do_reset();
        erdy_mode = 1;
        ChMask = 2'b11;
        for (int i = 0; i < (1 << AW) + 1; i++) push({$urandom, $urandom}, 2'b11);
        @(negedge Clk);
        IngressData = {$urandom, $urandom};
        IngressValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("full_ready", IngressReady, 0);
            @(negedge Clk);
        end
        IngressValid = 1'b0;
        #2;
        check("full_busy", Busy, 1);
        frames = 0;
        erdy_mode = 0;
        n = 0;
        while (IngressReady !== 1'b1 && n < 100) begin
            @(negedge Clk);
            #2;
            n++;
        end
        check("ready_after_pop", IngressReady, 1);
        check("ready_after_first_frame", frames, 1);
        drain();
        check("full_frames", frames, (1 << AW) + 1);

        // reset after the third byte of a frame, with another word queued
        ChMask = 2'b11;
        xfers = 0;
        push(W0, 2'b11);
        push({$urandom, $urandom}, 2'b11);
        n = 0;
        while (xfers < 3 && n < 100) begin
            @(negedge Clk);
            IngressValid = 1'b0;
            #2;
            n++;
        end
        check("mid_wait", 32'(xfers >= 3), 1);
        do_reset();
        idle(3);
        #2;
        check("post_rst_evalid", EValid, 0);
        check("post_rst_busy", Busy, 0);
        push({$urandom, $urandom}, 2'b11);
        drain();

        // empty mask
        ChMask = 2'b00;
        push({$urandom, $urandom}, 2'b00);
        drain();

        // random data, gaps, backpressure and masks
        erdy_mode = 3;
        for (int ph = 0; ph < 4; ph++) begin
            ChMask = 2'($urandom_range(0, 3));
            for (int i = 0; i < 25; i++) begin
                if ($urandom_range(0, 2) == 0) idle(1);
                push({$urandom, $urandom}, ChMask);
            end
            drain();
        end
        erdy_mode = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
